pipe_skid_reg: RTL and testbench

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

---
 rtl/pipe_skid_reg.sv | 129 ++++++++++++
 tb/tb_pipe_skid_reg.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_reg.sv
`timescale 1ns/1ps
// pipe_skid_reg: one-item pipeline register with an optional skid slot.
// Define PIPE_SKID_REG_SKID_EN to add the skid register and registered in_ready.
module pipe_skid_reg #(
    parameter int              WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       level
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] main_d;
    logic             in_xfer;
    logic             out_xfer;

`ifdef PIPE_SKID_REG_SKID_EN
    logic [WIDTH-1:0] skid_q;
    logic [WIDTH-1:0] skid_d;
    logic             in_ready_q;

    // in_ready comes straight from a flop, so out_ready never reaches it
    assign in_ready = in_ready_q;
`else
    // without a skid slot a full register frees up only as it drains
    assign in_ready = (state_q == EMPTY) || out_ready;
`endif

    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;

    // occupancy count derived from the state
    always_comb begin
        level = 2'd0;
        unique case (state_q)
            EMPTY:   level = 2'd0;
            FULL:    level = 2'd1;
            SKID:    level = 2'd2;
            default: level = 2'd0;
        endcase
    end

    // next state and data movement; flush discards everything
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
`ifdef PIPE_SKID_REG_SKID_EN
        skid_d  = skid_q;
`endif
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        state_d = FULL;
                        main_d  = in_data;
                    end
                end
                FULL: begin
                    if (in_xfer && out_xfer) begin
                        main_d = in_data;
                    end else if (out_xfer) begin
                        state_d = EMPTY;
`ifdef PIPE_SKID_REG_SKID_EN
                    end else if (in_xfer) begin
                        state_d = SKID;
                        skid_d  = in_data;
`endif
                    end
                end
                SKID: begin
`ifdef PIPE_SKID_REG_SKID_EN
                    if (out_xfer) begin
                        state_d = FULL;
                        main_d  = skid_q;
                    end
`else
                    state_d = EMPTY;
`endif
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // state and data registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= RESET_VAL;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
        end
    end

`ifdef PIPE_SKID_REG_SKID_EN
    // skid slot and registered ready flag
    always_ff @(posedge clk) begin
        if (rst) begin
            skid_q     <= RESET_VAL;
            in_ready_q <= 1'b1;
        end else begin
            skid_q     <= skid_d;
            in_ready_q <= (state_d != SKID);
        end
    end
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
`timescale 1ns/1ps
// tb_pipe_skid_reg: directed vector table plus randomized run against a queue model.
// Honors PIPE_SKID_REG_SKID_EN the same way as the design.
module tb_pipe_skid_reg;

    localparam int         W  = 16;
    localparam logic [W-1:0] RV = 16'h5A5A;
`ifdef PIPE_SKID_REG_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic [1:0]   level;

    int total = 0;
    int bad = 0;

    pipe_skid_reg #(.WIDTH(W), .RESET_VAL(RV)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .level(level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         r;
        logic         f;
        logic         iv;
        logic [W-1:0] d;
        logic         ordy;
        bit           chk;
        logic         ev;
        logic [1:0]   el;
        logic [W-1:0] ed;
        logic         eir;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(logic r, logic f, logic iv, logic [W-1:0] d,
                                logic ordy, bit chk, logic ev, logic [1:0] el,
                                logic [W-1:0] ed, logic eir);
        vec_t v;
        v.r = r; v.f = f; v.iv = iv; v.d = d; v.ordy = ordy;
        v.chk = chk; v.ev = ev; v.el = el; v.ed = ed; v.eir = eir;
        return v;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
        end
    endtask

    task automatic drive(logic r, logic f, logic iv, logic [W-1:0] d, logic ordy);
        @(negedge clk);
        rst = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
        #1;
    endtask

    logic [W-1:0] q[$];
    logic [W-1:0] hold;
    logic         m_ir;
    logic         ox;
    logic         ix;
    logic [W-1:0] prev_data;
    logic         prev_stall;

    initial begin
        // reset, stream, and the corner sequences
        tv.push_back(mk(1,0,0,16'h0000,0, 0, 0,0,RV,1));
        tv.push_back(mk(1,0,0,16'h0000,0, 1, 0,0,RV,1));
        tv.push_back(mk(0,0,0,16'h0000,1, 1, 0,0,RV,1));
        tv.push_back(mk(0,0,1,16'h0011,1, 1, 0,0,RV,1));
        tv.push_back(mk(0,0,1,16'h0022,1, 1, 1,1,16'h0011,1));
        tv.push_back(mk(0,0,1,16'h0033,1, 1, 1,1,16'h0022,1));
        tv.push_back(mk(0,0,0,16'h0000,1, 1, 1,1,16'h0033,1));
        tv.push_back(mk(0,0,0,16'h0000,0, 1, 0,0,16'h0033,1));
        if (SKID) begin
            tv.push_back(mk(0,0,1,16'h00A1,0, 1, 0,0,16'h0033,1));
            tv.push_back(mk(0,0,1,16'h00A2,0, 1, 1,1,16'h00A1,1));
            tv.push_back(mk(0,0,1,16'h00A3,0, 1, 1,2,16'h00A1,0));
            tv.push_back(mk(0,0,0,16'h0000,1, 1, 1,2,16'h00A1,0));
            tv.push_back(mk(0,0,0,16'h0000,0, 1, 1,1,16'h00A2,1));
            tv.push_back(mk(0,0,1,16'h00A4,0, 1, 1,1,16'h00A2,1));
            tv.push_back(mk(0,1,1,16'h00FF,0, 1, 1,2,16'h00A2,0));
            tv.push_back(mk(0,0,0,16'h0000,0, 1, 0,0,16'h00A2,1));
            tv.push_back(mk(0,0,1,16'h0077,0, 1, 0,0,16'h00A2,1));
            tv.push_back(mk(1,1,1,16'h0088,0, 1, 1,1,16'h0077,1));
            tv.push_back(mk(0,0,0,16'h0000,1, 1, 0,0,RV,1));
        end else begin
            tv.push_back(mk(0,0,1,16'h00A1,0, 1, 0,0,16'h0033,1));
            tv.push_back(mk(0,0,1,16'h00A2,0, 1, 1,1,16'h00A1,0));
            tv.push_back(mk(0,0,1,16'h00A2,1, 1, 1,1,16'h00A1,1));
            tv.push_back(mk(0,0,0,16'h0000,0, 1, 1,1,16'h00A2,0));
            tv.push_back(mk(0,1,1,16'h00FF,1, 1, 1,1,16'h00A2,1));
            tv.push_back(mk(0,0,0,16'h0000,0, 1, 0,0,16'h00A2,1));
            tv.push_back(mk(0,0,1,16'h0077,0, 1, 0,0,16'h00A2,1));
            tv.push_back(mk(1,1,1,16'h0088,0, 1, 1,1,16'h0077,0));
            tv.push_back(mk(0,0,0,16'h0000,0, 1, 0,0,RV,1));
        end

        foreach (tv[i]) begin
            drive(tv[i].r, tv[i].f, tv[i].iv, tv[i].d, tv[i].ordy);
            if (tv[i].chk) begin
                check($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'(tv[i].ev));
                check($sformatf("vec%0d level", i), 64'(level), 64'(tv[i].el));
                check($sformatf("vec%0d out_data", i), 64'(out_data), 64'(tv[i].ed));
                check($sformatf("vec%0d in_ready", i), 64'(in_ready), 64'(tv[i].eir));
            end
            @(posedge clk);
        end

        // randomized traffic against an ordered queue of accepted items
        q.delete();
        hold = RV;
        prev_stall = 1'b0;
        prev_data = RV;
        for (int c = 0; c < 10000; c++) begin
            drive(($urandom_range(0, 499) == 0),
                  ($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 9) < 7),
                  W'($urandom),
                  ($urandom_range(0, 9) < 6));
            m_ir = SKID ? (q.size() < 2) : (q.size() == 0 || out_ready);
            check("rnd out_valid", 64'(out_valid), 64'(q.size() > 0));
            check("rnd level", 64'(level), 64'(q.size()));
            check("rnd out_data", 64'(out_data), 64'(hold));
            check("rnd in_ready", 64'(in_ready), 64'(m_ir));
            if (prev_stall)
                check("rnd stall stable", 64'(out_data), 64'(prev_data));
            prev_stall = out_valid && !out_ready && !rst && !flush;
            prev_data = out_data;
            @(posedge clk);
            if (rst) begin
                q.delete();
                hold = RV;
            end else if (flush) begin
                q.delete();
            end else begin
                ox = (q.size() > 0) && out_ready;
                ix = in_valid && m_ir;
                if (ox) void'(q.pop_front());
                if (ix) q.push_back(in_data);
            end
            if (q.size() > 0) hold = q[0];
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
